// File: rtl/mmm_pkg.sv
// Shared types for the branch target buffer: geometry defaults, counter encoding,
// table entry layout and the fetch/branch-unit interface structs.
package mmm_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned BTB_ENTRIES = 64;
    localparam int unsigned BTB_IDX_W   = $clog2(BTB_ENTRIES);
    localparam int unsigned BTB_TAG_W   = XLEN - BTB_IDX_W - 2;

    // 2-bit saturating direction counter; MSB is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } btb_cnt_t;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [XLEN-1:0]      target;
        btb_cnt_t             cnt;
    } btb_entry_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            taken;
    } prediction_t;

    typedef struct packed {
        logic            valid;
        logic            mispredict;
        logic            taken;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } resolution_t;

    // Saturating train step: up on taken, down on not-taken.
    function automatic btb_cnt_t btb_cnt_next(btb_cnt_t cnt, logic taken);
        logic [1:0] raw;
        raw = cnt;
        if (taken) begin
            raw = (raw == 2'b11) ? raw : raw + 2'd1;
        end else begin
            raw = (raw == 2'b00) ? raw : raw - 2'd1;
        end
        return btb_cnt_t'(raw);
    endfunction

endpackage

// File: rtl/btb_cu.sv
// BTB control unit: INIT/RUN sequencing and the index walk that clears the table
// after reset or flush.
module btb_cu
    import mmm_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = mmm_pkg::BTB_ENTRIES,
    localparam int unsigned IDX_W      = $clog2(BTB_ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             init_we_o,
    output logic [IDX_W-1:0] init_idx_o
);

    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(BTB_ENTRIES - 1);

    state_e           state_q;
    logic [IDX_W-1:0] init_idx_q;

    // State and walk counter; flush restarts the walk from any state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StInit;
            init_idx_q <= '0;
        end else if (flush_i) begin
            state_q    <= StInit;
            init_idx_q <= '0;
        end else begin
            case (state_q)
                StInit: begin
                    init_idx_q <= init_idx_q + 1'b1;
                    if (init_idx_q == LastIdx) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    init_idx_q <= '0;
                end
                default: begin
                    state_q    <= StInit;
                    init_idx_q <= '0;
                end
            endcase
        end
    end

    // Status decode straight from the state register.
    always_comb begin
        ready_o    = (state_q == StRun);
        init_we_o  = (state_q == StInit);
        init_idx_o = init_idx_q;
    end

endmodule

// File: rtl/btb.sv
// Direct-mapped, tagged branch target buffer with 2-bit counters. Lookups return a
// registered prediction one cycle later; branch-unit results train the table.
module btb
    import mmm_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = mmm_pkg::BTB_ENTRIES
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            ready_o,
    output logic            hit_o,
    output prediction_t     pred_o,
    input  resolution_t     res_i
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    logic             init_we;
    logic [IDX_W-1:0] init_idx;

    btb_cu #(
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_cu (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .flush_i    (flush_i),
        .ready_o    (ready_o),
        .init_we_o  (init_we),
        .init_idx_o (init_idx)
    );

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]        target_q [BTB_ENTRIES];
    btb_cnt_t               cnt_q    [BTB_ENTRIES];

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             l_hit, l_taken, lookup_en;
    logic             u_hit, upd_en;
    logic [XLEN-1:0]  l_target;

    logic        hit_q;
    prediction_t pred_q;

    // Low PC bits and the mispredict flag play no part in indexing or training.
    logic unused_ok;
    assign unused_ok = ^{pc_i[1:0], res_i.pc[1:0], res_i.mispredict};

    // Lookup and update address decode against the current (pre-update) table.
    always_comb begin
        l_idx     = pc_i[IDX_W+1:2];
        l_tag     = pc_i[XLEN-1:IDX_W+2];
        l_hit     = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
        l_taken   = l_hit && cnt_q[l_idx][1];
        l_target  = l_taken ? target_q[l_idx] : pc_i + XLEN'(4);
        lookup_en = ready_o && valid_i;

        u_idx  = res_i.pc[IDX_W+1:2];
        u_tag  = res_i.pc[XLEN-1:IDX_W+2];
        u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        // Flush outranks a same-cycle update; updates outside RUN are dropped.
        upd_en = ready_o && res_i.valid && !flush_i;
    end

    // Table write port: init walk clears valid bits, otherwise train/allocate.
    always_ff @(posedge clk_i) begin
        if (init_we) begin
            valid_q[init_idx] <= 1'b0;
        end else if (upd_en) begin
            if (u_hit) begin
                cnt_q[u_idx] <= btb_cnt_next(cnt_q[u_idx], res_i.taken);
                if (res_i.taken) begin
                    target_q[u_idx] <= res_i.target;
                end
            end else if (res_i.taken) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= res_i.target;
                cnt_q[u_idx]    <= WT;
            end
        end
    end

    // Prediction register; pc/target hold when no lookup is accepted.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hit_q  <= 1'b0;
            pred_q <= '0;
        end else if (lookup_en) begin
            hit_q         <= l_hit;
            pred_q.pc     <= pc_i;
            pred_q.taken  <= l_taken;
            pred_q.target <= l_target;
        end else begin
            hit_q        <= 1'b0;
            pred_q.taken <= 1'b0;
        end
    end

    assign hit_o  = hit_q;
    assign pred_o = pred_q;

endmodule

// File: tb/tb_btb.sv
// Directed self-checking bench for the branch target buffer (64 entries, XLEN 32).
module tb_btb;
    import mmm_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            ready;
    logic            hit;
    prediction_t     pred;
    resolution_t     res;

    int n_cmp  = 0;
    int n_fail = 0;

    btb #(
        .BTB_ENTRIES (64)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .flush_i (flush),
        .valid_i (valid),
        .pc_i    (pc),
        .ready_o (ready),
        .hit_o   (hit),
        .pred_o  (pred),
        .res_i   (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", name, obs, exp);
        end
    endtask

    task automatic set_res(input logic [31:0] p, input logic [31:0] t, input logic tk);
        res = '{valid: 1'b1, mispredict: 1'b0, taken: tk, pc: p, target: t};
    endtask

    // One accepted update, inputs driven and released on falling edges.
    task automatic upd(input logic [31:0] p, input logic [31:0] t, input logic tk);
        set_res(p, t, tk);
        @(negedge clk);
        res = '0;
    endtask

    // One lookup; outputs are valid on return.
    task automatic lookup(input logic [31:0] p);
        valid = 1'b1;
        pc    = p;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic chk_pred(input string name, input logic h, input logic [31:0] p,
                            input logic [31:0] t, input logic tk);
        chk({name, ".hit"}, {31'd0, hit}, {31'd0, h});
        chk({name, ".pc"}, pred.pc, p);
        chk({name, ".target"}, pred.target, t);
        chk({name, ".taken"}, {31'd0, pred.taken}, {31'd0, tk});
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        valid = 1'b0;
        pc    = '0;
        res   = '0;
        #12;
        chk_pred("reset", 1'b0, 32'h0, 32'h0, 1'b0);
        chk("reset.ready", {31'd0, ready}, 32'd0);

        // Init walk with a lookup held on every cycle.
        valid = 1'b1;
        pc    = 32'h104;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("init.ready[%0d]", i), {31'd0, ready}, 32'd0);
            chk($sformatf("init.hit[%0d]", i), {31'd0, hit}, 32'd0);
            @(negedge clk);
        end
        chk("init.ready_up", {31'd0, ready}, 32'd1);
        chk("init.hit_after", {31'd0, hit}, 32'd0);
        valid = 1'b0;

        // Allocate and predict; low PC bits ignored.
        upd(32'h104, 32'h200, 1'b1);
        lookup(32'h104);
        chk_pred("alloc", 1'b1, 32'h104, 32'h200, 1'b1);
        lookup(32'h107);
        chk_pred("lowbits", 1'b1, 32'h107, 32'h200, 1'b1);

        // Counter: WT -> ST -> ST -> WT (taken) -> WNT (not taken).
        upd(32'h104, 32'h200, 1'b1);
        upd(32'h104, 32'h200, 1'b1);
        upd(32'h104, 32'h200, 1'b0);
        lookup(32'h104);
        chk_pred("hyst_wt", 1'b1, 32'h104, 32'h200, 1'b1);
        upd(32'h104, 32'h200, 1'b0);
        lookup(32'h104);
        chk_pred("hyst_wnt", 1'b1, 32'h104, 32'h108, 1'b0);

        // Aliasing on index 1: tag 2 vs tag 1.
        lookup(32'h204);
        chk_pred("alias_miss", 1'b0, 32'h204, 32'h208, 1'b0);
        upd(32'h204, 32'h400, 1'b1);
        lookup(32'h104);
        chk_pred("evicted", 1'b0, 32'h104, 32'h108, 1'b0);
        lookup(32'h204);
        chk_pred("alias_new", 1'b1, 32'h204, 32'h400, 1'b1);

        // Read-before-write on the same index.
        upd(32'h104, 32'h200, 1'b1);
        valid = 1'b1;
        pc    = 32'h104;
        set_res(32'h104, 32'h300, 1'b1);
        @(negedge clk);
        valid = 1'b0;
        res   = '0;
        chk_pred("rbw_old", 1'b1, 32'h104, 32'h200, 1'b1);
        lookup(32'h104);
        chk_pred("rbw_new", 1'b1, 32'h104, 32'h300, 1'b1);

        // No lookup: hit/taken clear, pc/target hold.
        @(negedge clk);
        chk_pred("idle_hold", 1'b0, 32'h104, 32'h300, 1'b0);

        // Fall-through target wraps modulo 2^32.
        lookup(32'hFFFF_FFFC);
        chk_pred("wrap", 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0);

        // Flush with a concurrent taken update; another update late in the walk.
        flush = 1'b1;
        set_res(32'h204, 32'h500, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        res   = '0;
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("flush.ready[%0d]", i), {31'd0, ready}, 32'd0);
            if (i == 60) set_res(32'h1000, 32'h700, 1'b1);
            else res = '0;
            @(negedge clk);
        end
        res = '0;
        chk("flush.ready_up", {31'd0, ready}, 32'd1);
        lookup(32'h104);
        chk_pred("flush_104", 1'b0, 32'h104, 32'h108, 1'b0);
        lookup(32'h204);
        chk_pred("flush_204", 1'b0, 32'h204, 32'h208, 1'b0);
        lookup(32'h1000);
        chk_pred("init_drop", 1'b0, 32'h1000, 32'h1004, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/btb.md
# btb

Branch target buffer feeding the fetch stage and trained by the branch unit. Given a fetch PC it returns a registered `prediction_t` (taken flag, target, PC) one cycle later; every valid `resolution_t` from the branch unit updates the table. Direct-mapped, tagged, with a 2-bit saturating counter per entry. Entries are cleared by an init walk after reset or flush.

## Interface
- `BTB_ENTRIES`, default 64: number of entries, power of two and at least 4; `IDX_W = $clog2(BTB_ENTRIES)`.
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  reset, asynchronous and active-low.
- `flush_i`  in  1  one-cycle pulse that invalidates the whole table.
- `valid_i`  in  1  lookup request.
- `pc_i`  in  XLEN  lookup PC.
- `ready_o`  out  1  table is operational; low during the init walk.
- `hit_o`  out  1  registered: previous lookup hit a valid, tag-matching entry.
- `pred_o`  out  prediction_t  registered prediction `{pc, target, taken}`.
- `res_i`  in  resolution_t  branch unit result: `valid`, `mispredict`, `taken`, `pc`, `target`.

## Operation
- **Address split**
  - index = `pc[IDX_W+1:2]`.
  - tag = `pc[XLEN-1:IDX_W+2]`.
  - `pc[1:0]` is ignored.
- **Entry contents**
  - `valid`.
  - tag.
  - target, XLEN bits.
  - `cnt`, 2 bits: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- **FSM states**
  - INIT: counter `init_idx` walks 0..BTB_ENTRIES-1 and clears `valid[init_idx]` each cycle. After the last index the FSM goes to RUN.
  - RUN: normal operation. `flush_i` in RUN sends the FSM to INIT with `init_idx=0`.
  - `flush_i` during INIT restarts the walk at 0.
- **Lookup** (RUN, `valid_i=1`)
  - hit = `valid[idx] && tag[idx]==tag(pc_i)`.
  - On the next edge the outputs register as:
    - `pred_o.pc = pc_i`.
    - `hit_o = hit`.
    - `pred_o.taken = hit && cnt[1]`.
    - `pred_o.target`: entry target if `pred_o.taken`, else `pc_i + 4` (mod 2^XLEN).
- **Lookup with `valid_i=0`, or in INIT:** `hit_o` and `pred_o.taken` register 0; `pred_o.pc` and `pred_o.target` hold.
- **Update** (RUN, `res_i.valid=1`)
  - Tag match on a valid entry: `cnt` increments saturating at 11 if `res_i.taken`, else decrements saturating at 00. Target is written with `res_i.target` when taken.
  - Miss and `res_i.taken=1`: allocate (overwrite) with valid=1, tag, target, `cnt=10`.
  - Miss and not taken: no write.
- **Updates during INIT are dropped.** Branch-unit results in flight at flush are discarded by design.
- **Same-cycle lookup and update to the same index:** lookup reads the pre-update contents (read-before-write). The update is visible from the next cycle.
- **Simultaneous `flush_i` and update:** flush wins; the update is dropped.

## Timing
- **Lookup latency:** 1 cycle, registered outputs. A lookup is accepted every cycle while `ready_o=1`.
- **Update latency:** write at the edge where `res_i.valid=1`; visible to a lookup in the following cycle.
- **Reset values**
  - FSM in INIT, `init_idx=0`.
  - `ready_o=0`, `hit_o=0`.
  - `pred_o = '0`.
  - Table arrays are not reset; the walk clears them.
- **`ready_o`** is combinational from the FSM state (`state==RUN`).
- **Init walk length:** `ready_o` rises exactly BTB_ENTRIES cycles after reset deassertion or after the flush edge.
- **Reset mid-walk or mid-operation** returns to INIT at `init_idx=0` asynchronously.

## Structure
- **mmm_pkg**
  - `BTB_ENTRIES` default.
  - `btb_cnt_t` enum (SNT, WNT, WT, ST).
  - `btb_entry_t` packed struct `{valid, tag, target, cnt}`.
  - Existing `prediction_t` and `resolution_t`.
- **Sub-module `btb_cu`:** INIT/RUN FSM plus `init_idx` counter. It outputs `ready_o`, `init_we` and `init_idx`.
- **Top-level `btb`:** table arrays, lookup path and output register.

## Test plan
All scenarios use BTB_ENTRIES=64, XLEN=32.
- **Reset and init:** release reset, hold `valid_i=1` → `ready_o=0` for exactly 64 cycles, then 1; `hit_o=0` throughout; `pred_o=0` at reset.
- **Allocate and predict:** res `{valid=1, taken=1, pc=0x0000_0104, target=0x0000_0200}`, then lookup `pc_i=0x104` → `hit_o=1`, `pred_o={pc=0x104, target=0x200, taken=1}`.
- **Counter saturation and hysteresis:** after allocation at 0x104 (cnt=10), two taken updates then one not-taken → cnt=11→11→10, still predicts taken. A second not-taken → cnt=01, `pred_o.taken=0`, target=0x108.
- **Aliasing:** after the 0x104 entry exists, lookup 0x0000_0204 (same index 1, tag 2 vs tag 1) → `hit_o=0`, target=0x208. A taken update at 0x204 evicts it; a lookup at 0x104 then misses.
- **Read-before-write:** same cycle, lookup 0x104 and taken update for 0x104 with target 0x300 → that lookup returns the old target 0x200; the next lookup returns 0x300.
- **Flush:** `flush_i` pulse together with a taken update → `ready_o=0` for 64 cycles, then lookup 0x104 misses and the concurrent update was not written.
